// File: rtl/rf_pkg.sv
// Shared defaults and elaboration helpers for the multiport register file.
// Packaged so the top, the write resolver and benches agree on the defaults.
package rf_pkg;

    localparam int RF_DW     = 32;
    localparam int RF_DEPTH  = 16;
    localparam int RF_NUM_RD = 3;
    localparam int RF_NUM_WR = 2;

    // Ceiling log2 usable in parameter defaults; returns 0 for values <= 1.
    function automatic int rf_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_wr_resolve.sv
// Combinational write-port arbitration: per-register winner, overall lowest
// enabled port, and same-address collision detection.
module rf_wr_resolve
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int DEPTH  = RF_DEPTH,
    parameter int AW     = rf_clog2(DEPTH),
    parameter int NUM_WR = RF_NUM_WR,
    parameter int PW     = (NUM_WR > 1) ? rf_clog2(NUM_WR) : 1
) (
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic [NUM_WR*DW-1:0] wr_data_i,
    output logic [DEPTH-1:0]     reg_we_o,
    output logic [DEPTH*DW-1:0]  reg_wdata_o,
    output logic [PW-1:0]        win_port_o,
    output logic                 wr_any_o,
    output logic                 collision_o
);

    // Ports are scanned from highest to lowest index so port 0 overrides last.
    always_comb begin
        reg_we_o    = '0;
        reg_wdata_o = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
                    reg_we_o[r]              = 1'b1;
                    reg_wdata_o[r*DW +: DW]  = wr_data_i[p*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        win_port_o = '0;
        wr_any_o   = |wr_en_i;
        for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en_i[p]) begin
                win_port_o = PW'(p);
            end
        end
    end

    always_comb begin
        collision_o = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_en_i[j] && wr_en_i[k] &&
                    (wr_addr_i[j*AW +: AW] == wr_addr_i[k*AW +: AW])) begin
                    collision_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised N-read/M-write register file between decode and writeback,
// with optional same-cycle write-through and a registered last-write bypass.
module multiport_reg_file
    import rf_pkg::*;
#(
    parameter int DW            = RF_DW,
    parameter int DEPTH         = RF_DEPTH,
    parameter int AW            = rf_clog2(DEPTH),
    parameter int NUM_RD        = RF_NUM_RD,
    parameter int NUM_WR        = RF_NUM_WR,
    parameter bit WRITE_THROUGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    output logic [DW-1:0]        last_wr_data,
    output logic [AW-1:0]        last_wr_addr,
    output logic                 last_wr_valid,
    output logic                 wr_collision
);

    localparam int PW = (NUM_WR > 1) ? rf_clog2(NUM_WR) : 1;

    logic [DEPTH-1:0]    reg_we;
    logic [DEPTH*DW-1:0] reg_wdata;
    logic [PW-1:0]       win_port;
    logic                wr_any;
    logic                collision;

    logic [DW-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0]        last_data_q, last_data_d;
    logic [AW-1:0]        last_addr_q, last_addr_d;
    logic                 last_valid_q, last_valid_d;
    logic                 collision_q;

    rf_wr_resolve #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NUM_WR (NUM_WR),
        .PW     (PW)
    ) u_resolve (
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .reg_we_o    (reg_we),
        .reg_wdata_o (reg_wdata),
        .win_port_o  (win_port),
        .wr_any_o    (wr_any),
        .collision_o (collision)
    );

    // With write-through the resolved write data bypasses the array so the
    // reader sees this cycle's commit; otherwise it sees pre-write contents.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_d[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
                if (WRITE_THROUGH && reg_we[rd_addr[i*AW +: AW]]) begin
                    rd_data_d[i*DW +: DW] = reg_wdata[rd_addr[i*AW +: AW]*DW +: DW];
                end
            end
        end
    end

    // With no port enabled win_port is 0, so port 0's inputs are captured.
    always_comb begin
        last_data_d  = wr_data[win_port*DW +: DW];
        last_addr_d  = wr_addr[win_port*AW +: AW];
        last_valid_d = wr_any & rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_we[r]) begin
                    mem_q[r] <= reg_wdata[r*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q    <= '0;
            last_data_q  <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            rd_data_q    <= rd_data_d;
            last_data_q  <= last_data_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
            collision_q  <= collision;
        end
    end

    assign rd_data       = rd_data_q;
    assign last_wr_data  = last_data_q;
    assign last_wr_addr  = last_addr_q;
    assign last_wr_valid = last_valid_q;
    assign wr_collision  = collision_q;

endmodule
